// File: rtl/drive_pkg.sv
// Shared types, constants and the gauge target helper for the drive controller.
package drive_pkg;

  typedef enum logic [1:0] {
    NEUTRAL = 2'd0,
    DRIVE   = 2'd1,
    SHIFT   = 2'd2
  } drive_state_t;

  localparam int LEVEL_MAX = 8;
  localparam int SHIFT_MS  = 200;
  localparam int COAST_MS  = 500;
  localparam int SERVO_MIN = 5;
  localparam int SERVO_MAX = 25;
  localparam int DUTY_STEP = 32;

  localparam logic [2:0] GEAR_NEUTRAL = 3'd0;

  // Gauge high-count for a given level and committed gear: base count plus half
  // the level*gear product, clipped at the gauge ceiling. Neutral (gear 0)
  // collapses the product to zero, so the needle rests at the base count.
  function automatic logic [4:0] gauge_target(input logic [3:0] level,
                                              input logic [2:0] gear);
    logic [6:0] v;
    logic [5:0] t;
    v = 7'(level) * 7'(gear);
    t = 6'(SERVO_MIN) + 6'(v >> 1);
    if (t > 6'(SERVO_MAX)) t = 6'(SERVO_MAX);
    return t[4:0];
  endfunction

endpackage

// File: rtl/drive_ctrl_gauge_ramp.sv
// Rate-limited servo gauge: one count per servo frame toward the target.
module gauge_ramp
  import drive_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [4:0] target,
  output logic [4:0] servo_high
);

  // Step the high-count by one toward the target at each frame start, hold when equal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      servo_high <= 5'(SERVO_MIN);
    end else if (frame_tick) begin
      if (servo_high < target)      servo_high <= servo_high + 5'd1;
      else if (servo_high > target) servo_high <= servo_high - 5'd1;
    end
  end

endmodule

// File: rtl/drive_ctrl.sv
// Speed level, gear and timed gear-shift sequencing for the car simulator top.
module drive_ctrl
  import drive_pkg::*;
(
  input  logic       clk_100mhz,
  input  logic       rst_n,
  input  logic       tick_1khz,
  input  logic       frame_tick,
  input  logic       accel_pulse,
  input  logic       decel_pulse,
  input  logic [2:0] gear_sw,
  output logic [7:0] dc_duty,
  output logic [4:0] servo_high,
  output logic [2:0] gear_cur,
  output logic [3:0] speed_level,
  output logic       shifting
);

  drive_state_t state;
  logic [2:0]   gear_sync1;
  logic [2:0]   gear_sync2;
  logic [2:0]   gear_req;
  logic [2:0]   shift_gear;
  logic [7:0]   shift_cnt;
  logic [8:0]   coast_cnt;
  logic         coast_dec;
  logic         level_inc;
  logic         level_dec;
  logic [8:0]   duty_raw;
  logic [7:0]   duty_next;
  logic [4:0]   target;

  // Two-flop synchronizer for the raw gear switch.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      gear_sync1 <= 3'd0;
      gear_sync2 <= 3'd0;
    end else begin
      gear_sync1 <= gear_sw;
      gear_sync2 <= gear_sync1;
    end
  end

  // Positions outside 1..5 on the switch all mean neutral.
  always_comb begin
    gear_req = gear_sync2;
    if (gear_sync2 == 3'd0 || gear_sync2 > 3'd5) gear_req = GEAR_NEUTRAL;
  end

  // Shift sequencer: any request differing from the committed gear starts a timed
  // shift; a new request mid-shift restarts the timer; commit on the last tick.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NEUTRAL;
      shifting   <= 1'b0;
      shift_cnt  <= 8'd0;
      shift_gear <= GEAR_NEUTRAL;
      gear_cur   <= GEAR_NEUTRAL;
    end else begin
      case (state)
        NEUTRAL, DRIVE: begin
          if (gear_req != gear_cur) begin
            state      <= SHIFT;
            shifting   <= 1'b1;
            shift_cnt  <= 8'd0;
            shift_gear <= gear_req;
          end
        end
        SHIFT: begin
          if (gear_req != shift_gear) begin
            shift_gear <= gear_req;
            shift_cnt  <= 8'd0;
          end else if (tick_1khz) begin
            if (shift_cnt == 8'(SHIFT_MS - 1)) begin
              gear_cur  <= gear_req;
              shifting  <= 1'b0;
              shift_cnt <= 8'd0;
              state     <= (gear_req != GEAR_NEUTRAL) ? DRIVE : NEUTRAL;
            end else begin
              shift_cnt <= shift_cnt + 8'd1;
            end
          end
        end
        default: begin
          state    <= NEUTRAL;
          shifting <= 1'b0;
        end
      endcase
    end
  end

  // Coasting decay fires on the last tick of each coast period while in neutral.
  always_comb begin
    coast_dec = (state == NEUTRAL) && tick_1khz && (coast_cnt == 9'(COAST_MS - 1));
    level_inc = accel_pulse && !decel_pulse && (state == DRIVE);
    level_dec = (decel_pulse && !accel_pulse) || coast_dec;
  end

  // Coast timer runs only in neutral and is cleared everywhere else.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      coast_cnt <= 9'd0;
    end else if (state != NEUTRAL) begin
      coast_cnt <= 9'd0;
    end else if (tick_1khz) begin
      coast_cnt <= coast_dec ? 9'd0 : coast_cnt + 9'd1;
    end
  end

  // Speed level with saturation at both ends; simultaneous up/down cancels.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      speed_level <= 4'd0;
    end else if (level_inc && !level_dec) begin
      if (speed_level != 4'(LEVEL_MAX)) speed_level <= speed_level + 4'd1;
    end else if (level_dec && !level_inc) begin
      if (speed_level != 4'd0) speed_level <= speed_level - 4'd1;
    end
  end

  // Motor duty is the scaled level clipped to 8 bits, only while driving.
  always_comb begin
    duty_raw  = 9'(speed_level) * 9'(DUTY_STEP);
    duty_next = (duty_raw > 9'd255) ? 8'hFF : duty_raw[7:0];
  end

  // Register the duty word so it trails the level by one cycle.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n)              dc_duty <= 8'd0;
    else if (state == DRIVE) dc_duty <= duty_next;
    else                     dc_duty <= 8'd0;
  end

  // During a shift gear_cur still holds the old gear, so the gauge target does too.
  assign target = gauge_target(speed_level, gear_cur);

  gauge_ramp u_gauge_ramp (
    .clk        (clk_100mhz),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .target     (target),
    .servo_high (servo_high)
  );

endmodule

// File: doc/drive_ctrl.md
# drive_ctrl

Sequencing controller between the debounced button/switch front end and the PWM/gauge datapath of the car-simulator top. Owns the speed level, the active gear and a timed gear-shift sequence. Issues the DC-motor duty word and a rate-limited servo gauge high-count (in 10 kHz ticks per 20 ms frame) to the PWM generators.

## Interface
- LEVEL_MAX, 8: top speed level (accel steps).
- SHIFT_MS, 200: shift duration in 1 ms ticks; duty forced to 0 meanwhile.
- COAST_MS, 500: in neutral, level decays by 1 every COAST_MS ticks.
- SERVO_MIN, 5: gauge high-count at zero speed.
- SERVO_MAX, 25: gauge high-count ceiling.

- clk_100mhz  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- tick_1khz  in  1  one-cycle strobe, every 1 ms.
- frame_tick  in  1  one-cycle strobe at the start of each 20 ms servo frame.
- accel_pulse  in  1  one-cycle debounced accelerate press.
- decel_pulse  in  1  one-cycle debounced decelerate press.
- gear_sw  in  3  raw gear switch; 1..5 drive, 0/6/7 neutral.
- dc_duty  out  8  DC PWM duty, 0..255.
- servo_high  out  5  servo high-count, SERVO_MIN..SERVO_MAX.
- gear_cur  out  3  committed gear, 0 = neutral.
- speed_level  out  4  current level, 0..LEVEL_MAX.
- shifting  out  1  high while in SHIFT.

## Operation
- gear_sw passes a 2-FF synchronizer; values 0, 6 and 7 map to 0 (gear_req).
- FSM states: NEUTRAL, DRIVE, SHIFT. Reset → NEUTRAL.
- NEUTRAL/DRIVE: gear_req != gear_cur → SHIFT, shift_cnt cleared.
- SHIFT: shift_cnt increments on tick_1khz. A gear_req change while in SHIFT clears shift_cnt (restart). At shift_cnt == SHIFT_MS−1 with a tick: gear_cur ← gear_req, next state DRIVE if gear_req != 0, else NEUTRAL.
- Level rules:
  - accel_pulse: +1, saturating at LEVEL_MAX; accepted only in DRIVE.
  - decel_pulse: −1, saturating at 0; accepted in any state.
  - accel and decel in the same cycle: no change.
  - NEUTRAL: coast_cnt counts tick_1khz. At COAST_MS−1 with a tick, level −1 (floor 0) and coast_cnt clears. coast_cnt clears on leaving NEUTRAL.
- dc_duty: DRIVE → min(255, level·32); NEUTRAL/SHIFT → 0. Registered.
- Gauge target:
  - v = level·gear_cur, 7 bits unsigned, max 40.
  - target = min(SERVO_MAX, SERVO_MIN + (v >> 1)).
  - gear_cur = 0 gives target = SERVO_MIN.
  - During SHIFT, target uses the old gear_cur.
- Gauge ramp: on frame_tick, servo_high moves ±1 toward target and holds when equal. Full swing of 20 counts takes 20 frames (400 ms).

## Timing
- Reset values: dc_duty 0, servo_high SERVO_MIN, gear_cur 0, speed_level 0, shifting 0, state NEUTRAL, all counters 0.
- gear_sw to gear_req: 2 cycles. gear_req change to shifting = 1: +1 cycle.
- accel/decel pulse to speed_level: 1 cycle. speed_level to dc_duty: +1 cycle.
- shifting falls, and gear_cur updates, in the cycle after the final tick. dc_duty goes nonzero 1 cycle after that.
- servo_high changes only in the cycle after frame_tick; target is sampled in the frame_tick cycle.
- Reset mid-operation (mid-shift or mid-ramp) returns all outputs to reset values asynchronously. No pending shift survives reset.

## Structure
- Package drive_pkg:
  - state enum (NEUTRAL, DRIVE, SHIFT).
  - GEAR_NEUTRAL, DUTY_STEP = 32 constants.
  - gauge_target function (level, gear → 5-bit count).
- Sub-module gauge_ramp: target in, frame_tick in, servo_high out, reset to SERVO_MIN.
- Expected size about 200 lines RTL.

## Test plan
- Reset, gear_sw = 1 → shifting high for 200 ticks, then gear_cur = 1, DRIVE. Five accel_pulse → speed_level 5, dc_duty 160. After 20 frames, servo_high = 7.
- Gear 1 → 3 at level 5: dc_duty 0 for exactly 200 ms, then 160. servo_high ramps 7 → 12 over 5 frames (one step per frame).
- Ten accel_pulse in gear 5 → level saturates at 8, dc_duty 255, servo_high reaches 25 and holds.
- accel_pulse and decel_pulse in the same cycle → speed_level unchanged. decel_pulse at level 0 → stays 0.
- gear_sw 2 → 4 at 100 ms into the shift → shift restarts. gear_cur = 4 at 300 ms after the first change. gear_sw = 7 → neutral.
- NEUTRAL at level 4: level 0 after 2000 ticks, dc_duty 0, servo_high back to 5. Assert rst_n low mid-ramp → all outputs at reset values immediately.
